// File: rtl/paddle_motion_controller_if.sv
// Paddle controller bundle: frame/button/control inputs and paddle geometry/status outputs.
// master drives the controls and observes the paddle; slave is the controller itself.
interface paddle_motion_controller_if;
  logic       frame_tick;
  logic       btn_up;
  logic       btn_down;
  logic       enable;
  logic       center_req;
  logic [9:0] x_paddle;
  logic [9:0] y_paddle;
  logic [7:0] height_paddle;
  logic [7:0] width_paddle;
  logic       at_top;
  logic       at_bottom;
  logic       moving;

  modport master (
    output frame_tick, btn_up, btn_down, enable, center_req,
    input  x_paddle, y_paddle, height_paddle, width_paddle, at_top, at_bottom, moving
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, enable, center_req,
    output x_paddle, y_paddle, height_paddle, width_paddle, at_top, at_bottom, moving
  );
endinterface

// File: rtl/paddle_motion_controller.sv
// Paddle y-position FSM with slow/fast stepping, wall clamping and recentre requests.
// Position and flags update only at frame_tick (one edge of latency); no backpressure.
module paddle_motion_controller #(
  parameter int X_POS        = 20,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 480,
  parameter int STEP_SLOW    = 2,
  parameter int STEP_FAST    = 8,
  parameter int ACCEL_FRAMES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  paddle_motion_controller_if.slave    bus
);

  localparam int                 CENTER   = (Y_MIN + Y_MAX - PADDLE_H) / 2;
  localparam logic [9:0]         CENTER_Y = 10'(CENTER);
  localparam logic [9:0]         Y_LO     = 10'(Y_MIN);
  localparam logic [9:0]         Y_HI     = 10'(Y_MAX - PADDLE_H);
  localparam logic signed [10:0] Y_LO_S   = 11'(Y_MIN);
  localparam logic [10:0]        Y_HI_U   = 11'(Y_MAX - PADDLE_H);
  localparam logic [7:0]         SLOW     = 8'(STEP_SLOW);
  localparam logic [7:0]         FAST     = 8'(STEP_FAST);
  localparam logic [3:0]         ACC      = 4'(ACCEL_FRAMES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic              su_meta_q, su_q, sd_meta_q, sd_q;
  logic [1:0]        state_q, state_d;
  logic [3:0]        hold_q, hold_d;
  logic [9:0]        y_q, y_d;
  logic              pend_q, pend_d;
  logic              at_top_q, at_bottom_q, moving_q;
  logic [1:0]        dir;
  logic [7:0]        step;
  logic signed [10:0] up_s;
  logic [10:0]       dn_u;

  always_comb begin
    if (su_q && !sd_q)      dir = ST_UP;
    else if (sd_q && !su_q) dir = ST_DOWN;
    else                    dir = ST_IDLE;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    y_d     = y_q;
    pend_d  = pend_q;
    step    = SLOW;
    up_s    = '0;
    dn_u    = '0;
    if (bus.frame_tick) begin
      pend_d = 1'b0;
      // A recentre (latched or arriving this edge) beats both motion and pause.
      if (pend_q || bus.center_req) begin
        y_d     = CENTER_Y;
        state_d = ST_IDLE;
        hold_d  = '0;
      end else if (!bus.enable || dir == ST_IDLE) begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end else begin
        if (dir != state_q) begin
          state_d = dir;
          hold_d  = 4'd1;
          step    = SLOW;
        end else begin
          hold_d = (hold_q >= ACC) ? ACC : hold_q + 4'd1;
          step   = (hold_d == ACC) ? FAST : SLOW;
        end
        up_s = $signed({1'b0, y_q}) - $signed({3'b000, step});
        dn_u = {1'b0, y_q} + {3'b000, step};
        if (dir == ST_UP) y_d = (up_s < Y_LO_S) ? Y_LO : up_s[9:0];
        else              y_d = (dn_u > Y_HI_U) ? Y_HI : dn_u[9:0];
      end
    end else if (bus.center_req) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      su_meta_q   <= 1'b0;
      su_q        <= 1'b0;
      sd_meta_q   <= 1'b0;
      sd_q        <= 1'b0;
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      y_q         <= CENTER_Y;
      pend_q      <= 1'b0;
      at_top_q    <= 1'b0;
      at_bottom_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      su_meta_q   <= bus.btn_up;
      su_q        <= su_meta_q;
      sd_meta_q   <= bus.btn_down;
      sd_q        <= sd_meta_q;
      state_q     <= state_d;
      hold_q      <= hold_d;
      y_q         <= y_d;
      pend_q      <= pend_d;
      at_top_q    <= (y_d == Y_LO);
      at_bottom_q <= (y_d == Y_HI);
      moving_q    <= (state_d == ST_UP) || (state_d == ST_DOWN);
    end
  end

  assign bus.x_paddle      = 10'(X_POS);
  assign bus.y_paddle      = y_q;
  assign bus.height_paddle = 8'(PADDLE_H);
  assign bus.width_paddle  = 8'(PADDLE_W);
  assign bus.at_top        = at_top_q;
  assign bus.at_bottom     = at_bottom_q;
  assign bus.moving        = moving_q;

endmodule

// File: tb/tb_paddle_motion_controller.sv
// Frame-level vector table plus hand sequences for recentre, pause, glitch and reset corners.
module tb_paddle_motion_controller;

  typedef struct {
    bit         up;
    bit         dn;
    bit         en;
    logic [9:0] y;
    bit         mv;
    bit         top;
    bit         bot;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  paddle_motion_controller_if bus();

  paddle_motion_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit up, input bit dn, input bit en, input int y,
                     input bit mv, input bit top, input bit bot);
    vec_t v;
    v.up = up; v.dn = dn; v.en = en; v.y = 10'(y);
    v.mv = mv; v.top = top; v.bot = bot;
    vecs.push_back(v);
  endtask

  // Pulses frame_tick for one clock; expectation is queued before the edge, compared after it.
  task automatic tick(input string name, input bit ctr, input int y,
                      input bit mv, input bit top, input bit bot);
    vec_t e;
    e.up = 0; e.dn = 0; e.en = 1; e.y = 10'(y); e.mv = mv; e.top = top; e.bot = bot;
    exp_q.push_back(e);
    bus.frame_tick = 1'b1;
    bus.center_req = ctr;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.center_req = 1'b0;
    e = exp_q.pop_front();
    check({name, ".y"},      int'(bus.y_paddle), int'(e.y));
    check({name, ".moving"}, int'(bus.moving),   int'(e.mv));
    check({name, ".at_top"}, int'(bus.at_top),   int'(e.top));
    check({name, ".at_bot"}, int'(bus.at_bottom), int'(e.bot));
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.enable     = 1'b1;
    bus.center_req = 1'b0;

    // Idle frames, held up with acceleration, both-pressed cancel, pause.
    for (int k = 0; k < 5; k++) add(0, 0, 1, 208, 0, 0, 0);
    for (int k = 1; k <= 7; k++) add(1, 0, 1, 208 - 2 * k, 1, 0, 0);
    add(1, 0, 1, 186, 1, 0, 0);
    add(1, 0, 1, 178, 1, 0, 0);
    add(1, 0, 1, 170, 1, 0, 0);
    add(0, 0, 1, 170, 0, 0, 0);
    for (int k = 1; k <= 5; k++) add(1, 0, 1, 170 - 2 * k, 1, 0, 0);
    add(1, 1, 1, 160, 0, 0, 0);
    add(1, 0, 1, 158, 1, 0, 0);
    add(1, 0, 1, 156, 1, 0, 0);
    add(0, 0, 1, 156, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 156, 0, 0, 0);
    // Walk down to 410, stop, then press into the bottom wall.
    for (int k = 1; k <= 7; k++) add(0, 1, 1, 156 + 2 * k, 1, 0, 0);
    add(0, 1, 1, 178, 1, 0, 0);
    for (int k = 1; k <= 29; k++) add(0, 1, 1, 178 + 8 * k, 1, 0, 0);
    add(0, 0, 1, 410, 0, 0, 0);
    add(0, 1, 1, 412, 1, 0, 0);
    add(0, 1, 1, 414, 1, 0, 0);
    add(0, 1, 1, 416, 1, 0, 1);
    add(0, 1, 1, 416, 1, 0, 1);
    add(0, 1, 1, 416, 1, 0, 1);
    add(0, 0, 1, 416, 0, 0, 1);
    // Run all the way up into the top wall.
    for (int k = 1; k <= 7; k++) add(1, 0, 1, 416 - 2 * k, 1, 0, 0);
    add(1, 0, 1, 394, 1, 0, 0);
    for (int k = 1; k <= 50; k++) begin
      int yy;
      yy = 394 - 8 * k;
      if (yy < 0) yy = 0;
      add(1, 0, 1, yy, 1, (yy == 0), 0);
    end
    add(1, 0, 1, 0, 1, 1, 0);

    repeat (3) @(negedge clk);
    check("rst.y",      int'(bus.y_paddle), 208);
    check("rst.moving", int'(bus.moving), 0);
    check("rst.at_top", int'(bus.at_top), 0);
    check("rst.at_bot", int'(bus.at_bottom), 0);
    check("x_paddle",   int'(bus.x_paddle), 20);
    check("height",     int'(bus.height_paddle), 64);
    check("width",      int'(bus.width_paddle), 8);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.btn_up   = vecs[i].up;
      bus.btn_down = vecs[i].dn;
      bus.enable   = vecs[i].en;
      repeat (4) @(negedge clk);
      tick($sformatf("vec%0d", i), 1'b0, int'(vecs[i].y), vecs[i].mv, vecs[i].top, vecs[i].bot);
    end

    // Mid-frame recentre at the top with down held: position waits for the tick.
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b1;
    repeat (3) @(negedge clk);
    bus.center_req = 1'b1;
    @(negedge clk);
    bus.center_req = 1'b0;
    repeat (3) @(negedge clk);
    check("ctr_wait.y", int'(bus.y_paddle), 0);
    check("ctr_wait.at_top", int'(bus.at_top), 1);
    tick("ctr_apply", 1'b0, 208, 0, 0, 0);

    // Recentre arriving on the tick edge itself.
    repeat (2) @(negedge clk);
    tick("down_after_ctr", 1'b0, 210, 1, 0, 0);
    repeat (2) @(negedge clk);
    tick("ctr_same_edge", 1'b1, 208, 0, 0, 0);

    // One-clock button glitch between ticks never reaches a tick.
    bus.btn_down = 1'b0;
    repeat (3) @(negedge clk);
    tick("idle", 1'b0, 208, 0, 0, 0);
    bus.btn_up = 1'b1;
    @(negedge clk);
    bus.btn_up = 1'b0;
    repeat (4) @(negedge clk);
    tick("glitch", 1'b0, 208, 0, 0, 0);

    // Reset mid-move with a pending recentre: both are discarded.
    bus.btn_up = 1'b1;
    repeat (3) @(negedge clk);
    tick("pre_rst1", 1'b0, 206, 1, 0, 0);
    repeat (3) @(negedge clk);
    tick("pre_rst2", 1'b0, 204, 1, 0, 0);
    bus.center_req = 1'b1;
    @(negedge clk);
    bus.center_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst.y", int'(bus.y_paddle), 208);
    check("async_rst.moving", int'(bus.moving), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst.y", int'(bus.y_paddle), 208);
    tick("post_rst", 1'b0, 206, 1, 0, 0);
    bus.btn_up = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/paddle_motion_controller.md
PADDLE_MOTION_CONTROLLER -- requirements
Module: paddle_motion_controller

Interface
REQ-001 Parameter: X_POS, 20, fixed left x coordinate of the paddle in pixels.
REQ-002 Parameter: PADDLE_H, 64, paddle height in pixels (fits 8 bits).
REQ-003 Parameter: PADDLE_W, 8, paddle width in pixels (fits 8 bits).
REQ-004 Parameter: Y_MIN, 0, topmost allowed y_paddle.
REQ-005 Parameter: Y_MAX, 480, bottom screen limit; the paddle bottom edge y_paddle+PADDLE_H never exceeds it.
REQ-006 Parameter: STEP_SLOW, 2, pixels per frame before acceleration.
REQ-007 Parameter: STEP_FAST, 8, pixels per frame after acceleration.
REQ-008 Parameter: ACCEL_FRAMES, 8, consecutive same-direction frames before switching to STEP_FAST.
REQ-009 Clocking: one clock; reset is asynchronous and active-high.
REQ-010 clk  in  1  system clock (pixel clock domain).
REQ-011 rst  in  1  asynchronous active-high reset.
REQ-012 frame_tick  in  1  one-cycle pulse per frame at vertical blanking start; synchronous to clk.
REQ-013 btn_up  in  1  raw asynchronous up button, active-high.
REQ-014 btn_down  in  1  raw asynchronous down button, active-high.
REQ-015 enable  in  1  synchronous; low = game paused, motion frozen.
REQ-016 center_req  in  1  synchronous one-cycle request to recentre the paddle.
REQ-017 x_paddle  out  10  paddle left x; constant X_POS.
REQ-018 y_paddle  out  10  paddle top y, registered.
REQ-019 height_paddle  out  8  constant PADDLE_H.
REQ-020 width_paddle  out  8  constant PADDLE_W.
REQ-021 at_top  out  1  registered; high when y_paddle == Y_MIN.
REQ-022 at_bottom  out  1  registered; high when y_paddle == Y_MAX-PADDLE_H.
REQ-023 moving  out  1  registered; high when state is UP or DOWN.

Function
REQ-024 btn_up and btn_down SHALL each pass through a 2-flop synchronizer; only the synchronized values (su, sd) are used.
REQ-025 y_paddle, state, hold counter SHALL change only on a clk edge where frame_tick=1, so the downstream paddle renderer sees a stable position for an entire frame.
REQ-026 Requested direction: su&!sd = UP; sd&!su = DOWN; both or neither = NONE.
REQ-027 FSM states IDLE, UP, DOWN; hold counter 4 bits, saturates at ACCEL_FRAMES.
REQ-028 At frame_tick with enable=0 or direction NONE: state<=IDLE, hold<=0, y unchanged.
REQ-029 At frame_tick with direction differing from current state: state<=direction, hold<=1, step=STEP_SLOW.
REQ-030 At frame_tick with direction equal to current state: hold<=min(hold+1, ACCEL_FRAMES); step=STEP_FAST if new hold == ACCEL_FRAMES else STEP_SLOW.
REQ-031 UP move: computed in 11-bit signed; y<=Y_MIN if y-step < Y_MIN else y-step.
REQ-032 DOWN move: computed in 11 bits; y<=Y_MAX-PADDLE_H if y+step > Y_MAX-PADDLE_H else y+step.
REQ-033 Clamping SHALL NOT change state or hold; pressing into a wall keeps moving=1 with y fixed at the limit.
REQ-034 center_req SHALL set a pending flag; at the next frame_tick, y<=CENTER=(Y_MIN+Y_MAX-PADDLE_H)/2 (truncating), state<=IDLE, hold<=0, flag cleared; overrides motion and enable.
REQ-035 center_req coincident with frame_tick SHALL be serviced at that same edge.
REQ-036 at_top/at_bottom/moving SHALL be derived from next-state values and update on the same edge as y_paddle.

Reset
REQ-037 On rst high, immediately: y_paddle=CENTER (208 with defaults), state=IDLE, hold=0, pending=0, synchronizers=0, moving=0, at_top=0, at_bottom=0.
REQ-038 Reset asserted mid-frame or mid-move SHALL discard the pending request and motion; first update after release occurs at the next frame_tick.

Verification
REQ-039 Reset release, no buttons, 5 frame_ticks -> y_paddle=208, moving=0, constant throughout.
REQ-040 btn_up held 10 frames from 208 -> y after ticks 1..7 = 206..194 step 2; tick 8 = 186; ticks 9,10 = 178,170.
REQ-041 btn_down held from 410 -> tick 1 y=412 (clamp 416 not reached), tick 2 y=414, tick 3 y=416, at_bottom=1, moving=1; further ticks y=416.
REQ-042 Both buttons pressed while in UP with hold=5 -> next tick: state IDLE, y unchanged, moving=0; release to up only -> hold restarts at 1, step 2.
REQ-043 center_req pulsed mid-frame with y=0 and btn_down held -> y stays 0 until the next frame_tick, then y=208, moving=0, at_top=0.
REQ-044 enable=0 with btn_up held over 3 ticks -> y unchanged, moving=0; btn_up toggled shorter than 2 clk between ticks -> no motion.
